timer_cmd_ctrl: RTL

Command-driven sequencer that configures and runs the timer/counter core inside the tt_um_timer_counter_UGM top.
- Accepts byte-wide opcodes over a valid/ready handshake.
- Holds shadow reload and prescale registers, sequences load/enable of the counter, and raises a sticky interrupt with overrun detection.
- Sits between the pin-level command decoder and the counter datapath.

---
 rtl/timer_cmd_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/timer_cmd_ctrl.sv
// Command sequencer for the timer/counter core: byte-wide opcodes configure shadow
// reload/prescale registers and drive the load/enable/expiry flow of the counter.
module timer_cmd_ctrl #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             cnt_zero,
  input  logic             irq_ack,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic [PRE_W-1:0] cnt_prescale,
  output logic             cnt_en,
  output logic             irq,
  output logic             ovf,
  output logic             busy,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SET_LO  = 3'd1,
    OP_SET_HI  = 3'd2,
    OP_SET_PRE = 3'd3,
    OP_START   = 3'd4,
    OP_STOP    = 3'd5,
    OP_PAUSE   = 3'd6,
    OP_RESUME  = 3'd7
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   reload_q, reload_d;
  logic [PRE_W-1:0]   prescale_q, prescale_d;
  logic               periodic_q, periodic_d;
  logic [WIDTH-1:0]   load_val_q, load_val_d;
  logic [PRE_W-1:0]   load_pre_q, load_pre_d;
  logic               irq_q, irq_d;
  logic               ovf_q, ovf_d;

  // Handshake: a command is consumed on any cycle with cmd_valid && cmd_ready.
  // cmd_ready is low only during the single LOAD cycle; every other state
  // accepts every opcode, and opcodes a state does not act on are dropped.
  logic  accept;
  op_e   op;
  logic  expire;
  logic  is_start, is_stop, is_pause, is_resume;

  assign cmd_ready = (state_q != ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign op        = op_e'(cmd_op);
  assign is_start  = accept && (op == OP_START);
  assign is_stop   = accept && (op == OP_STOP);
  assign is_pause  = accept && (op == OP_PAUSE);
  assign is_resume = accept && (op == OP_RESUME);

  // Shadow configuration: only reaches the counter when LOAD is entered.
  always_comb begin
    reload_d   = reload_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    if (accept) begin
      case (op)
        OP_SET_LO:  reload_d[7:0]       = cmd_data;
        OP_SET_HI:  reload_d[WIDTH-1:8] = cmd_data[WIDTH-9:0];
        OP_SET_PRE: prescale_d          = cmd_data[PRE_W-1:0];
        OP_START:   periodic_d          = cmd_data[0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_start) begin
          if (reload_q == '0) begin
            state_d = ST_DONE;
            expire  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        expire = cnt_zero;
        // Explicit control commands take priority over the expiry transition.
        if (is_stop)       state_d = ST_IDLE;
        else if (is_pause) state_d = ST_PAUSE;
        else if (is_start) state_d = ST_LOAD;
        else if (cnt_zero) state_d = periodic_q ? ST_LOAD : ST_DONE;
      end
      ST_PAUSE: begin
        if (is_resume)     state_d = ST_RUN;
        else if (is_stop)  state_d = ST_IDLE;
        else if (is_start) state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (is_start)      state_d = ST_LOAD;
        else if (is_stop)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter-facing values are captured on LOAD entry so they are stable while cnt_load is high.
  always_comb begin
    load_val_d = load_val_q;
    load_pre_d = load_pre_q;
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      load_val_d = reload_d;
      load_pre_d = prescale_d;
    end
  end

  // A new expiry beats a same-cycle acknowledge; the earlier event counts as acknowledged.
  always_comb begin
    irq_d = irq_q;
    ovf_d = ovf_q;
    if (expire) begin
      irq_d = 1'b1;
      ovf_d = irq_ack ? 1'b0 : (ovf_q | irq_q);
    end else if (irq_ack) begin
      irq_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      reload_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      load_val_q <= '0;
      load_pre_q <= '0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      load_val_q <= load_val_d;
      load_pre_q <= load_pre_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cnt_load     = (state_q == ST_LOAD);
  assign cnt_en       = (state_q == ST_RUN);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign cnt_load_val = load_val_q;
  assign cnt_prescale = load_pre_q;
  assign irq          = irq_q;
  assign ovf          = ovf_q;
  assign state        = state_q;

endmodule
